// File: rtl/bin2bcd_seq_pkg.sv
// Shared state encoding and digit-correction threshold for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bin2bcd_seq_bcd_add3.sv
// Combinational double-dabble digit corrector: digits >= 5 get +3 (mod 16), others pass through.
// Zero latency; no flow control.
module bcd_add3
  import bin2bcd_seq_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= ADD3_THRESH) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter, one correct+shift step per clock; done BIN_W+1 cycles after start.
// Backpressure: start is accepted only while ready (IDLE); it is dropped, not queued, in SHIFT and DONE.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  state_t             state;
  state_t             state_nxt;
  logic [BIN_W-1:0]   sh;
  logic [BCD_W-1:0]   acc;
  logic [BCD_W-1:0]   acc_cor;
  logic [BCD_W-1:0]   acc_nxt;
  logic               ovf;
  logic               ovf_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               at_last;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .din  (acc[4*g +: 4]),
      .dout (acc_cor[4*g +: 4])
    );
  end

  // The bit leaving the top digit is a decimal carry we cannot hold; it only marks overflow.
  assign acc_nxt = {acc_cor[BCD_W-2:0], sh[BIN_W-1]};
  assign ovf_nxt = ovf | acc_cor[BCD_W-1];
  assign at_last = (cnt == LAST);

  assign ready = (state == IDLE);
  assign busy  = (state == SHIFT);
  assign done  = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (at_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sh       <= '0;
      acc      <= '0;
      ovf      <= 1'b0;
      cnt      <= '0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            sh  <= bin;
            acc <= '0;
            ovf <= 1'b0;
            cnt <= '0;
          end
        end
        SHIFT: begin
          sh  <= sh << 1;
          acc <= acc_nxt;
          ovf <= ovf_nxt;
          cnt <= cnt + CNT_W'(1);
          if (at_last) begin
            bcd      <= acc_nxt;
            overflow <= ovf_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: three parameterisations checked against a decimal-arithmetic reference.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        start_a, ready_a, busy_a, done_a, ovf_a;
  logic [7:0]  bin_a;
  logic [11:0] bcd_a;

  logic        start_b, ready_b, busy_b, done_b, ovf_b;
  logic [3:0]  bin_b;
  logic [7:0]  bcd_b;

  logic        start_c, ready_c, busy_c, done_c, ovf_c;
  logic [7:0]  bin_c;
  logic [7:0]  bcd_c;

  int total = 0;
  int bad   = 0;
  logic [11:0] last_exp [3];

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bin(bin_a), .ready(ready_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a));

  bin2bcd_seq #(.BIN_W(4), .DIGITS(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bin(bin_b), .ready(ready_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b));

  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_c), .bin(bin_c), .ready(ready_c),
    .busy(busy_c), .done(done_c), .bcd(bcd_c), .overflow(ovf_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int bw_of(input int sel);
    return (sel == 1) ? 4 : 8;
  endfunction

  function automatic int dg_of(input int sel);
    return (sel == 0) ? 3 : 2;
  endfunction

  function automatic int pow10(input int d);
    int p = 1;
    repeat (d) p = p * 10;
    return p;
  endfunction

  // Low d decimal digits of v, one nibble each.
  function automatic logic [11:0] ref_bcd(input int v, input int d);
    logic [11:0] r = '0;
    int x = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic sample(input int sel, output logic r, output logic b, output logic d,
                        output logic o, output logic [11:0] q);
    case (sel)
      0:       begin r = ready_a; b = busy_a; d = done_a; o = ovf_a; q = bcd_a; end
      1:       begin r = ready_b; b = busy_b; d = done_b; o = ovf_b; q = {4'h0, bcd_b}; end
      default: begin r = ready_c; b = busy_c; d = done_c; o = ovf_c; q = {4'h0, bcd_c}; end
    endcase
  endtask

  task automatic drive(input int sel, input logic s, input int v);
    case (sel)
      0:       begin start_a = s; bin_a = v[7:0]; end
      1:       begin start_b = s; bin_b = v[3:0]; end
      default: begin start_c = s; bin_c = v[7:0]; end
    endcase
  endtask

  task automatic conv(input int sel, input int v);
    logic r, b, d, o;
    logic [11:0] q;
    logic [11:0] e;
    int k, lat;
    bit fin;
    sample(sel, r, b, d, o, q);
    check($sformatf("ready_idle%0d", sel), r, 1);
    drive(sel, 1'b1, v);
    @(negedge clk);
    drive(sel, 1'b0, v);
    k = 1; lat = 0; fin = 0;
    while (!fin) begin
      sample(sel, r, b, d, o, q);
      if (d) begin
        lat = k; fin = 1;
      end else if (k >= 64) begin
        fin = 1;
      end else begin
        check($sformatf("busy%0d", sel), b, 1);
        check($sformatf("ready_busy%0d", sel), r, 0);
        check($sformatf("bcd_hold%0d", sel), q, last_exp[sel]);
        @(negedge clk);
        k++;
      end
    end
    e = ref_bcd(v, dg_of(sel));
    check($sformatf("latency%0d v=%0d", sel, v), lat, bw_of(sel) + 1);
    check($sformatf("bcd%0d v=%0d", sel, v), q, e);
    check($sformatf("ovf%0d v=%0d", sel, v), o, (v >= pow10(dg_of(sel))) ? 1 : 0);
    check($sformatf("ready_done%0d", sel), r, 0);
    last_exp[sel] = e;
    @(negedge clk);
    sample(sel, r, b, d, o, q);
    check($sformatf("done_once%0d", sel), d, 0);
    check($sformatf("ready_after%0d", sel), r, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r, b, d, o;
    logic [11:0] q;
    int vals [3];
    int k, idx, prev, dones, lat, sel, v;

    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      drive(s, 1'b0, 0);
      last_exp[s] = '0;
    end
    repeat (3) @(negedge clk);
    sample(0, r, b, d, o, q);
    check("rst_ready", r, 1);
    check("rst_busy", b, 0);
    check("rst_done", d, 0);
    check("rst_bcd", q, 0);
    check("rst_ovf", o, 0);
    rst = 1'b0;
    @(negedge clk);

    conv(0, 0);
    conv(0, 99);
    conv(0, 100);
    conv(0, 255);

    // Back-to-back with start held high: one done every 10 cycles.
    vals = '{255, 99, 100};
    drive(0, 1'b1, vals[0]);
    k = 0; idx = 0; prev = 0;
    while (idx < 3 && k < 100) begin
      @(negedge clk);
      k++;
      sample(0, r, b, d, o, q);
      if (d) begin
        check("b2b_bcd", q, ref_bcd(vals[idx], 3));
        check("b2b_gap", k - prev, (idx == 0) ? 9 : 10);
        prev = k;
        last_exp[0] = ref_bcd(vals[idx], 3);
        idx++;
        if (idx < 3) drive(0, 1'b1, vals[idx]);
        else drive(0, 1'b0, 0);
      end
    end
    check("b2b_count", idx, 3);
    drive(0, 1'b0, 0);
    @(negedge clk);

    for (int i = 0; i < 16; i++) conv(1, i);

    conv(2, 99);
    conv(2, 200);
    conv(2, 255);
    conv(2, 0);

    // A start pulsed mid-conversion must be dropped.
    drive(0, 1'b1, 42);
    @(negedge clk);
    drive(0, 1'b0, 42);
    dones = 0; lat = 0;
    for (int c = 1; c <= 20; c++) begin
      sample(0, r, b, d, o, q);
      if (d) begin
        dones++;
        if (lat == 0) begin
          lat = c;
          check("ign_bcd", q, 12'h042);
        end
      end else if (lat == 0) begin
        check("ign_hold", q, last_exp[0]);
      end
      if (c == 3) drive(0, 1'b1, 7);
      else drive(0, 1'b0, 7);
      @(negedge clk);
    end
    check("ign_dones", dones, 1);
    check("ign_lat", lat, 9);
    last_exp[0] = 12'h042;

    // Reset in the middle of SHIFT aborts with no done.
    drive(0, 1'b1, 200);
    @(negedge clk);
    drive(0, 1'b0, 200);
    dones = 0;
    for (int c = 1; c <= 3; c++) begin
      sample(0, r, b, d, o, q);
      if (d) dones++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) last_exp[s] = '0;
    sample(0, r, b, d, o, q);
    check("abort_ready", r, 1);
    check("abort_busy", b, 0);
    check("abort_bcd", q, 0);
    check("abort_ovf", o, 0);
    for (int c = 0; c < 12; c++) begin
      sample(0, r, b, d, o, q);
      if (d) dones++;
      @(negedge clk);
    end
    check("abort_dones", dones, 0);
    conv(0, 13);

    repeat (40) begin
      sel = int'($urandom_range(0, 2));
      v = int'($urandom_range(0, (sel == 1) ? 15 : 255));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      conv(sel, v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Iterative shift-add-3 (double-dabble) binary-to-BCD converter with a start/done handshake.
- Sequences one correction-plus-shift step per clock, so a wide binary input converts with one row of digit-correction cells instead of a combinational array.
- Used wherever a registered binary value must be shown on decimal displays or sent out as BCD.

Parameters:
- BIN_W, 8, width of the binary input; number of shift iterations.
- DIGITS, 3, number of BCD digits produced; bcd width is 4*DIGITS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request conversion of bin; sampled only when ready=1.
- bin  in  BIN_W  unsigned binary operand; sampled on the accepted start edge only.
- ready  out  1  high in IDLE; block accepts start.
- busy  out  1  high while iterating (SHIFT state).
- done  out  1  one-cycle pulse; bcd and overflow are valid from this cycle on.
- bcd  out  4*DIGITS  result, digit 0 in bits [3:0], most significant digit on top.
- overflow  out  1  result did not fit in DIGITS digits.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, ready=1, busy=0, done=0, bcd=0, overflow=0, counter=0, working regs=0.
- A reset in any state, including mid-SHIFT, aborts the conversion. No done is produced and the outputs clear on the next edge.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 -> load bin into shift register sh, clear working BCD register acc and sticky ovf, counter=0, go to SHIFT.
  - start=0 -> stay.
- SHIFT, each cycle:
  - For each digit d of acc: if d>=5 then d=d+3 (4-bit, no carry between digits).
  - Then shift {ovf_bit, acc, sh} left by 1. The bit leaving the top digit ORs into sticky ovf.
  - counter++.
  - When counter reaches BIN_W-1 on this edge: copy corrected and shifted acc to bcd, ovf to overflow, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Start is ignored in SHIFT and DONE. It is not queued, and bin changes during those states have no effect.
- Latency: start sampled at edge of cycle 0 -> busy in cycles 1..BIN_W -> done=1 in cycle BIN_W+1. Next start is accepted in cycle BIN_W+2. Default latency is 9 cycles.
- bcd and overflow hold their values from done until the next done or reset. They do not change during a later conversion.
- Overflow: overflow=1 iff bin > 10^DIGITS-1. In that case bcd holds the low DIGITS digits of the decimal value.
- Counter width: clog2(BIN_W)+1. BIN_W=1 is legal (single SHIFT cycle).
- bin=0 -> bcd=0, overflow=0. All-ones input follows the normal path with no special-casing.

Decomposition:
- Shared package or header: state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the constant ADD3_THRESH=4'd5.
- Sub-module bcd_add3: 4-bit combinational digit corrector, out = (in>=5) ? in+3 : in.
  - Instantiated DIGITS times with a generate loop.
  - Unit-testable over all 16 inputs: 0-4 pass through, 5-9 -> 8-12, 10-15 don't-care but deterministic (+3 mod 16).

Test Plan:
1. Reset, then start with bin=8'd0 -> done at cycle 9 after start, bcd=12'h000, overflow=0; ready=0 during cycles 1..9, ready=1 from cycle 10.
2. bin=8'd255 -> bcd=12'h255, overflow=0. bin=8'd99 -> bcd=12'h099. bin=8'd100 -> bcd=12'h100. Run back-to-back with start held high: each done occurs exactly 10 cycles after the previous one.
3. BIN_W=4, DIGITS=2, sweep bin 0..15 -> bcd 8'h00..8'h15 (e.g. 10->8'h10, 15->8'h15), done always 5 cycles after start.
4. BIN_W=8, DIGITS=2: bin=99 -> bcd=8'h99, overflow=0. bin=200 -> overflow=1, bcd=8'h00. bin=255 -> overflow=1, bcd=8'h55.
5. Start bin=8'd42. In cycle 3 pulse start with bin=8'd7 -> ignored, result bcd=12'h042 with a single done pulse. Previous bcd stays stable until that done.
6. Start bin=8'd200, assert rst in cycle 4 -> no done pulse, bcd=0 and ready=1 after the reset edge. A fresh start with bin=8'd13 -> bcd=12'h013 after 9 cycles.
